// File: rtl/fetch_tgen_pkg.sv
// Shared types and constants for the multi-port instruction-fetch traffic generator.
package fetch_tgen_pkg;

  typedef enum logic [1:0] {
    MODE_SEQ    = 2'd0,
    MODE_RANDOM = 2'd1,
    MODE_STRIDE = 2'd2,
    MODE_RSVD   = 2'd3
  } fetch_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DRAIN,
    ST_DONE
  } port_state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Galois form: shift right, fold the polynomial in when a one falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/fetch_tgen_port.sv
// One fetch port: request FSM, address generator, LFSR, outstanding tracking.
module fetch_tgen_port
  import fetch_tgen_pkg::*;
#(
  parameter int unsigned FETCH_ADDR_WIDTH = 32,
  parameter int unsigned FETCH_DATA_WIDTH = 128,
  parameter int unsigned N_TRANS          = 1024,
  parameter int unsigned MAX_OUTST        = 2,
  parameter logic [31:0] ADDR_MASK        = 32'h0000_0FF0,
  parameter logic [31:0] SEED             = 32'hACE1_0001
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_enable_i,
  input  logic [1:0]                  mode_i,
  input  logic [FETCH_ADDR_WIDTH-1:0] stride_i,
  input  logic [1:0]                  gap_i,
  output logic                        fetch_req_o,
  output logic [FETCH_ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                        fetch_gnt_i,
  input  logic                        fetch_rvalid_i,
  input  logic [FETCH_DATA_WIDTH-1:0] fetch_rdata_i,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned IW = $clog2(N_TRANS + 1);
  localparam logic [OW-1:0] MAX_O  = OW'(MAX_OUTST);
  localparam logic [IW-1:0] LAST_I = IW'(N_TRANS);
  localparam logic [FETCH_ADDR_WIDTH-1:0] MASK = FETCH_ADDR_WIDTH'(ADDR_MASK);
  localparam logic [FETCH_ADDR_WIDTH-1:0] STEP = FETCH_ADDR_WIDTH'(FETCH_DATA_WIDTH / 8);

  port_state_e                 state;
  logic [31:0]                 lfsr;
  logic [OW-1:0]               outst, outst_nx;
  logic [IW-1:0]               issued, issued_inc;
  logic [1:0]                  gap_cnt, gap_len;
  logic                        grant, can_req, last;
  logic [FETCH_ADDR_WIDTH-1:0] addr_nx, first_addr;

  assign grant      = fetch_req_o & fetch_gnt_i;
  assign issued_inc = issued + 1'b1;
  assign last       = (issued_inc == LAST_I);
  assign gap_len    = (gap_i == 2'd3) ? lfsr[1:0] : gap_i;
  assign done_o     = (state == ST_DONE);

  // A stray response with nothing outstanding leaves the counter at zero.
  always_comb begin
    outst_nx = outst;
    if (grant && !fetch_rvalid_i)
      outst_nx = outst + 1'b1;
    else if (!grant && fetch_rvalid_i && outst != '0)
      outst_nx = outst - 1'b1;
  end

  // Request decisions look at the post-update count so a response frees a slot
  // in time for the very next cycle.
  assign can_req = fetch_enable_i && (outst_nx < MAX_O);

  always_comb begin
    case (fetch_mode_e'(mode_i))
      MODE_RANDOM: addr_nx = FETCH_ADDR_WIDTH'(lfsr_step(lfsr)) & MASK;
      MODE_STRIDE: addr_nx = (fetch_addr_o + stride_i) & MASK;
      default:     addr_nx = (fetch_addr_o + STEP) & MASK;
    endcase
    first_addr = (fetch_mode_e'(mode_i) == MODE_RANDOM) ? (FETCH_ADDR_WIDTH'(lfsr) & MASK) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      lfsr         <= SEED;
      outst        <= '0;
      issued       <= '0;
      gap_cnt      <= '0;
      fetch_req_o  <= 1'b0;
      fetch_addr_o <= '0;
      err_o        <= 1'b0;
    end else begin
      outst <= outst_nx;
      if (fetch_rvalid_i && outst == '0) err_o <= 1'b1;
      case (state)
        ST_IDLE: if (fetch_enable_i) begin
          state        <= ST_REQ;
          fetch_addr_o <= first_addr;
          fetch_req_o  <= can_req;
        end
        ST_REQ: if (fetch_req_o) begin
          if (fetch_gnt_i) begin
            issued       <= issued_inc;
            lfsr         <= lfsr_step(lfsr);
            fetch_addr_o <= addr_nx;
            fetch_req_o  <= 1'b0;
            if (gap_len != '0) begin
              state   <= ST_GAP;
              gap_cnt <= gap_len;
            end else if (last) begin
              state <= ST_DRAIN;
            end else begin
              fetch_req_o <= can_req;
            end
          end
        end else begin
          fetch_req_o <= can_req;
        end
        ST_GAP: if (gap_cnt == 2'd1) begin
          if (issued == LAST_I) begin
            state <= ST_DRAIN;
          end else begin
            state       <= ST_REQ;
            fetch_req_o <= can_req;
          end
        end else begin
          gap_cnt <= gap_cnt - 1'b1;
        end
        ST_DRAIN: if (outst_nx == '0) state <= ST_DONE;
        default: ;
      endcase
    end
  end

  // Read data carries no payload for this generator; only its definedness is policed.
  always_ff @(posedge clk) begin
    if (rst_n && fetch_rvalid_i) assert (!$isunknown(fetch_rdata_i));
  end

endmodule

// File: rtl/fetch_tgen_mp.sv
// Multi-port fetch traffic generator: NB_PORTS independent ports plus end-of-run flag.
module fetch_tgen_mp
  import fetch_tgen_pkg::*;
#(
  parameter int unsigned NB_PORTS         = 4,
  parameter int unsigned FETCH_ADDR_WIDTH = 32,
  parameter int unsigned FETCH_DATA_WIDTH = 128,
  parameter int unsigned N_TRANS          = 1024,
  parameter int unsigned MAX_OUTST        = 2,
  parameter logic [31:0] ADDR_MASK        = 32'h0000_0FF0,
  parameter logic [31:0] SEED             = 32'hACE1_0001
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       fetch_enable_i,
  input  logic [1:0]                                 mode_i,
  input  logic [FETCH_ADDR_WIDTH-1:0]                stride_i,
  input  logic [1:0]                                 gap_i,
  output logic [NB_PORTS-1:0]                        fetch_req_o,
  output logic [NB_PORTS-1:0][FETCH_ADDR_WIDTH-1:0]  fetch_addr_o,
  input  logic [NB_PORTS-1:0]                        fetch_gnt_i,
  input  logic [NB_PORTS-1:0]                        fetch_rvalid_i,
  input  logic [NB_PORTS-1:0][FETCH_DATA_WIDTH-1:0]  fetch_rdata_i,
  output logic                                       eoc_o,
  output logic [NB_PORTS-1:0]                        err_o
);

  logic [NB_PORTS-1:0] done;

  for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
    fetch_tgen_port #(
      .FETCH_ADDR_WIDTH (FETCH_ADDR_WIDTH),
      .FETCH_DATA_WIDTH (FETCH_DATA_WIDTH),
      .N_TRANS          (N_TRANS),
      .MAX_OUTST        (MAX_OUTST),
      .ADDR_MASK        (ADDR_MASK),
      .SEED             (SEED ^ 32'(p))
    ) u_port (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_enable_i (fetch_enable_i),
      .mode_i         (mode_i),
      .stride_i       (stride_i),
      .gap_i          (gap_i),
      .fetch_req_o    (fetch_req_o[p]),
      .fetch_addr_o   (fetch_addr_o[p]),
      .fetch_gnt_i    (fetch_gnt_i[p]),
      .fetch_rvalid_i (fetch_rvalid_i[p]),
      .fetch_rdata_i  (fetch_rdata_i[p]),
      .done_o         (done[p]),
      .err_o          (err_o[p])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eoc_o <= 1'b0;
    else        eoc_o <= &done;
  end

endmodule
